// File: rtl/mvu_pkg.sv
// Shared MVU dispatch types and sizes.
package mvu_pkg;

    localparam int NMVU    = 8;
    localparam int BCNTDWN = 29;
    localparam int MVU_IW  = $clog2(NMVU) + 1;

    // Index is one bit wider than needed so out-of-range targets are representable.
    typedef struct packed {
        logic [MVU_IW-1:0]  mvu;
        logic [BCNTDWN-1:0] cnt;
    } mvu_job_t;

endpackage

// File: rtl/mvu_job_fifo.sv
// In-order job queue with registered occupancy; ready never depends on a same-cycle pop.
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  mvu_job_t                   push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output mvu_job_t                   head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    mvu_job_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_ready = (count < CW'(DEPTH));
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvu_job_dispatch.sv
// Queues MVU jobs and dispatches them in order to idle MVUs, tracking busy/irq.
// Optional watchdog enabled by defining MVU_JOB_TIMEOUT_EN.
module mvu_job_dispatch
    import mvu_pkg::*;
#(
    parameter int NMVU    = mvu_pkg::NMVU,
    parameter int BCNTDWN = mvu_pkg::BCNTDWN,
    parameter int QDEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [$clog2(NMVU):0]         job_mvu,
    input  logic [BCNTDWN-1:0]            job_cntdwn,
    output logic [NMVU-1:0]               start,
    output logic [NMVU*BCNTDWN-1:0]       countdown,
    input  logic [NMVU-1:0]               done,
    output logic [NMVU-1:0]               busy,
    output logic [NMVU-1:0]               irq,
    input  logic [NMVU-1:0]               irq_ack,
    output logic                          bad_job,
`ifdef MVU_JOB_TIMEOUT_EN
    input  logic [31:0]                   to_limit,
    output logic [NMVU-1:0]               timeout,
`endif
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    localparam int MW = $clog2(NMVU) + 1;

    mvu_job_t                       push_job;
    mvu_job_t                       head;
    logic                           head_valid;
    logic                           pop;
    logic                           bad;
    logic [NMVU-1:0]                disp;
    logic [NMVU-1:0]                fin;
    logic [NMVU-1:0]                to_fire;
    logic [NMVU-1:0][BCNTDWN-1:0]   cd_q;

    assign push_job  = '{mvu: job_mvu, cnt: job_cntdwn};
    assign countdown = cd_q;

    mvu_job_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (job_valid),
        .push_ready (job_ready),
        .push_data  (push_job),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (q_count)
    );

    // Busy is registered, so a done this cycle lets the waiting head go next cycle.
    always_comb begin
        disp = '0;
        bad  = 1'b0;
        if (head_valid) begin
            bad = (head.mvu >= MW'(NMVU));
            for (int m = 0; m < NMVU; m++)
                if (head.mvu == MW'(m) && !busy[m])
                    disp[m] = 1'b1;
        end
        pop = bad || (|disp);
    end

    assign fin = done & busy;

`ifdef MVU_JOB_TIMEOUT_EN
    logic [NMVU-1:0][31:0] to_cnt;

    always_comb begin
        to_fire = '0;
        for (int m = 0; m < NMVU; m++)
            to_fire[m] = busy[m] && (to_limit != 32'd0) && (to_cnt[m] >= to_limit - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= '0;
        end else begin
            timeout <= (timeout & ~irq_ack) | to_fire;
            for (int m = 0; m < NMVU; m++) begin
                if (disp[m])      to_cnt[m] <= '0;
                else if (busy[m]) to_cnt[m] <= to_cnt[m] + 32'd1;
            end
        end
    end
`else
    assign to_fire = '0;
`endif

    // A new completion wins over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start   <= '0;
            busy    <= '0;
            irq     <= '0;
            bad_job <= 1'b0;
            cd_q    <= '0;
        end else begin
            start   <= disp;
            bad_job <= bad;
            busy    <= (busy & ~(fin | to_fire)) | disp;
            irq     <= (irq & ~irq_ack) | fin | to_fire;
            for (int m = 0; m < NMVU; m++)
                if (disp[m]) cd_q[m] <= head.cnt;
        end
    end

endmodule

// File: tb/tb_mvu_job_dispatch.sv
// Randomized scoreboard bench for mvu_job_dispatch against a queue-level reference model.
module tb_mvu_job_dispatch;

    localparam int NMVU    = 8;
    localparam int BCNTDWN = 29;
    localparam int QDEPTH  = 4;
    localparam int MW      = $clog2(NMVU) + 1;
    localparam int CW      = $clog2(QDEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     job_valid = 1'b0;
    logic                     job_ready;
    logic [MW-1:0]            job_mvu = '0;
    logic [BCNTDWN-1:0]       job_cntdwn = '0;
    logic [NMVU-1:0]          start;
    logic [NMVU*BCNTDWN-1:0]  countdown;
    logic [NMVU-1:0]          done = '0;
    logic [NMVU-1:0]          busy;
    logic [NMVU-1:0]          irq;
    logic [NMVU-1:0]          irq_ack = '0;
    logic                     bad_job;
    logic [CW-1:0]            q_count;
`ifdef MVU_JOB_TIMEOUT_EN
    logic [31:0]              to_limit = '0;
    logic [NMVU-1:0]          timeout;
`endif

    mvu_job_dispatch #(.NMVU(NMVU), .BCNTDWN(BCNTDWN), .QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_mvu    (job_mvu),
        .job_cntdwn (job_cntdwn),
        .start      (start),
        .countdown  (countdown),
        .done       (done),
        .busy       (busy),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .bad_job    (bad_job),
`ifdef MVU_JOB_TIMEOUT_EN
        .to_limit   (to_limit),
        .timeout    (timeout),
`endif
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 mvu;
        logic [BCNTDWN-1:0] cnt;
    } job_t;

    typedef struct {
        logic [NMVU-1:0] st;
        logic            bad;
    } ev_t;

    // Reference model: a job list, per-MVU flags, and the edge index of each dispatch.
    job_t               mq[$];
    ev_t                eq[$];
    bit                 mbusy [NMVU];
    bit                 mirq  [NMVU];
    bit                 mto   [NMVU];
    logic [BCNTDWN-1:0] mcd   [NMVU];
    int                 mstart[NMVU];
    int                 cyc = 0;
    bit                 started = 1'b0;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   nb[NMVU], ni[NMVU], nt[NMVU];
        bit   rdy;
        job_t h, j;
        ev_t  e;
        cyc++;
        if (rst) begin
            mq.delete();
            eq.delete();
            for (int m = 0; m < NMVU; m++) begin
                mbusy[m] = 0; mirq[m] = 0; mto[m] = 0; mcd[m] = '0; mstart[m] = 0;
            end
            return;
        end
        rdy = (mq.size() < QDEPTH);
        for (int m = 0; m < NMVU; m++) begin
            nb[m] = mbusy[m];
            ni[m] = mirq[m] && !irq_ack[m];
            nt[m] = mto[m] && !irq_ack[m];
        end
        if (mq.size() != 0) begin
            h = mq[0];
            if (h.mvu >= NMVU) begin
                e.st = '0; e.bad = 1'b1; eq.push_back(e);
                void'(mq.pop_front());
            end else if (!mbusy[h.mvu]) begin
                e.st = '0; e.st[h.mvu] = 1'b1; e.bad = 1'b0; eq.push_back(e);
                nb[h.mvu] = 1; mcd[h.mvu] = h.cnt; mstart[h.mvu] = cyc;
                void'(mq.pop_front());
            end
        end
        for (int m = 0; m < NMVU; m++) begin
            if (done[m] && mbusy[m]) begin
                nb[m] = 0; ni[m] = 1;
            end
`ifdef MVU_JOB_TIMEOUT_EN
            if (mbusy[m] && to_limit != 0 && longint'(cyc - mstart[m]) >= longint'(to_limit)) begin
                nb[m] = 0; ni[m] = 1; nt[m] = 1;
            end
`endif
        end
        if (job_valid && rdy) begin
            j.mvu = int'(job_mvu); j.cnt = job_cntdwn;
            mq.push_back(j);
        end
        for (int m = 0; m < NMVU; m++) begin
            mbusy[m] = nb[m]; mirq[m] = ni[m]; mto[m] = nt[m];
        end
    endtask

    // Monitor: consumes one expected dispatch event whenever the DUT shows one or one is due.
    logic [NMVU-1:0]         eb, ei, et;
    logic [NMVU*BCNTDWN-1:0] ecd;
    ev_t                     ev;
    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < NMVU; m++) begin
                eb[m] = mbusy[m]; ei[m] = mirq[m]; et[m] = mto[m];
                ecd[m*BCNTDWN +: BCNTDWN] = mcd[m];
            end
            if (start != '0 || bad_job || eq.size() != 0) begin
                if (eq.size() == 0) begin
                    ev.st = '0; ev.bad = 1'b0;
                end else begin
                    ev = eq.pop_front();
                end
                chk("start", start, ev.st);
                chk("bad_job", bad_job, ev.bad);
            end
            chk("busy", busy, eb);
            chk("irq", irq, ei);
            chk("q_count", q_count, mq.size());
            chk("job_ready", job_ready, mq.size() < QDEPTH);
            chk("countdown", countdown, ecd);
`ifdef MVU_JOB_TIMEOUT_EN
            chk("timeout", timeout, et);
`endif
        end
    end

    task automatic step(input bit v, input int mvu, input logic [BCNTDWN-1:0] c,
                        input logic [NMVU-1:0] d, input logic [NMVU-1:0] a);
        job_valid = v; job_mvu = MW'(mvu); job_cntdwn = c; done = d; irq_ack = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1; job_valid = 1'b0; done = '0; irq_ack = '0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [NMVU-1:0] rd, ra;
    int              rmv;

    initial begin
        @(posedge clk); model_step();
        @(posedge clk); model_step();
        @(negedge clk);
        started = 1'b1;
        rst = 1'b0;

        // Single job to an idle MVU.
        step(1, 2, 29'd100, '0, '0);
        idle(2);

        // Head-of-line: MVU1 busy, then {1},{3} wait for done[1].
        step(1, 1, 29'd7, '0, '0);
        idle(1);
        step(1, 1, 29'd8, '0, '0);
        step(1, 3, 29'd10, '0, '0);
        idle(3);
        step(0, 0, '0, 8'h02, '0);
        idle(3);

        // Queue fills behind busy MVU1; the fifth offer is held off.
        for (int i = 0; i < 5; i++) step(1, 1, 29'(20 + i), '0, '0);
        step(1, 1, 29'd30, '0, '0);
        idle(2);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 8'hFF, '0);

        // Out-of-range target is dropped with a bad_job pulse.
        step(1, NMVU, 29'd55, '0, '0);
        step(1, 4, 29'd56, '0, '0);
        idle(3);

        // done and irq_ack together on a busy MVU0: irq stays set.
        step(1, 0, 29'd77, '0, '0);
        idle(2);
        step(0, 0, '0, 8'h01, 8'h01);
        idle(1);
        step(0, 0, '0, '0, 8'hFF);

`ifdef MVU_JOB_TIMEOUT_EN
        do_reset();
        to_limit = 32'd10;
        step(1, 5, 29'd500, '0, '0);
        idle(13);
        step(0, 0, '0, '0, 8'h20);
        idle(1);
        to_limit = 32'd0;
`endif

        // Randomized traffic, with a reset dropped in mid-stream.
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            rd = '0; ra = '0;
            for (int m = 0; m < NMVU; m++) begin
                if ($urandom_range(0, 5) == 0) rd[m] = 1'b1;
                if ($urandom_range(0, 7) == 0) ra[m] = 1'b1;
            end
            rmv = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, NMVU);
            step($urandom_range(0, 1) == 1, rmv, BCNTDWN'($urandom), rd, ra);
        end
        for (int i = 0; i < 10; i++) step(0, 0, '0, 8'hFF, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "bench time limit reached");
    end

endmodule
